// File: rtl/accel_tx_packetizer_if.sv
// accel_tx_packetizer_if: sample input, UART TX handshake and status bundle for accel_tx_packetizer
interface accel_tx_packetizer_if;
  logic        i_sample_valid;
  logic [15:0] i_x;
  logic [15:0] i_y;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic        i_Tx_Done;
  logic        o_busy;
  logic [7:0]  o_drop_cnt;
  modport master (
    input  i_sample_valid, i_x, i_y, i_Tx_Done,
    output o_Tx_DV, o_Tx_Byte, o_busy, o_drop_cnt
  );
  modport slave (
    output i_sample_valid, i_x, i_y, i_Tx_Done,
    input  o_Tx_DV, o_Tx_Byte, o_busy, o_drop_cnt
  );
endinterface

// File: rtl/accel_tx_packetizer.sv
// accel_tx_packetizer: frames X/Y samples into bytes for a UART TX core; PKT_CHECKSUM_EN appends an XOR byte
module accel_tx_packetizer #(
  parameter logic [7:0] HEADER     = 8'hAA,
  parameter int         GAP_CYCLES = 0
) (
  input logic clk_50,
  input logic rst,
  accel_tx_packetizer_if.master bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;
  state_t      state;
  logic [2:0]  idx;
  logic [15:0] fx, fy, px, py;
  logic        pend;
  logic [15:0] gap_cnt;
  logic [7:0]  drop;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [2:0]  ni;
  logic [7:0]  tail;
  logic [7:0]  nxt_byte;
`ifdef PKT_CHECKSUM_EN
  localparam logic [2:0] LAST = 3'd5;
  assign tail = fx[15:8] ^ fx[7:0] ^ fy[15:8] ^ fy[7:0];
`else
  localparam logic [2:0] LAST = 3'd4;
  assign tail = 8'h00;
`endif
  assign ni = idx + 3'd1;
  always_comb nxt_byte = ni == 3'd1 ? fx[15:8] : ni == 3'd2 ? fx[7:0] :
                         ni == 3'd3 ? fy[15:8] : ni == 3'd4 ? fy[7:0] : tail;
  assign bus.o_Tx_DV    = tx_dv;
  assign bus.o_Tx_Byte  = tx_byte;
  assign bus.o_busy     = state != IDLE;
  assign bus.o_drop_cnt = drop;
  // tx_dv is raised on every transition into SEND, so it is high exactly during the SEND cycle
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 3'd0;
      fx      <= 16'h0;
      fy      <= 16'h0;
      px      <= 16'h0;
      py      <= 16'h0;
      pend    <= 1'b0;
      gap_cnt <= 16'h0;
      drop    <= 8'h0;
      tx_dv   <= 1'b0;
      tx_byte <= 8'h0;
    end else begin
      tx_dv <= 1'b0;
      if (bus.i_sample_valid && state != IDLE) begin
        px   <= bus.i_x;
        py   <= bus.i_y;
        pend <= 1'b1;
        if (pend && drop != 8'hFF) drop <= drop + 8'd1;
      end
      case (state)
        IDLE: begin
          if (pend || bus.i_sample_valid) begin
            fx      <= pend ? px : bus.i_x;
            fy      <= pend ? py : bus.i_y;
            idx     <= 3'd0;
            tx_dv   <= 1'b1;
            tx_byte <= HEADER;
            state   <= SEND;
          end
          // a pending load frees the slot, which an arriving sample refills at once
          if (pend) pend <= bus.i_sample_valid;
          if (pend && bus.i_sample_valid) begin
            px <= bus.i_x;
            py <= bus.i_y;
          end
        end
        SEND: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (bus.i_Tx_Done && idx == LAST) begin
            state   <= GAP_CYCLES > 0 ? GAP : IDLE;
            gap_cnt <= 16'(GAP_CYCLES - 1);
          end else if (bus.i_Tx_Done) begin
            idx     <= ni;
            tx_dv   <= 1'b1;
            tx_byte <= nxt_byte;
            state   <= SEND;
          end
        end
        GAP: begin
          if (gap_cnt == 16'h0) state <= IDLE;
          else gap_cnt <= gap_cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accel_tx_packetizer.sv
// tb_accel_tx_packetizer: directed and randomized checks of accel_tx_packetizer against a frame/slot model
module tb_accel_tx_packetizer;
  localparam int G = 4;
`ifdef PKT_CHECKSUM_EN
  localparam int N = 6;
`else
  localparam int N = 5;
`endif
  logic clk_50 = 0, rst = 1;
  logic done_auto = 0, done_man = 0, auto_done = 0, prev_busy = 0;
  int cyc = 0, resp_cnt = 0, checks = 0, errors = 0, m_drop = 0, fall_cyc = -1;
  logic [7:0] got[$], exp_q[$];
  int got_cyc[$], done_cyc[$];

  accel_tx_packetizer_if bus();
  accel_tx_packetizer #(.GAP_CYCLES(G)) dut (.clk_50(clk_50), .rst(rst), .bus(bus));
  assign bus.i_Tx_Done = done_auto | done_man;

  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  // byte monitor, busy-fall tracker and UART stand-in answering 10 cycles after each strobe
  always @(negedge clk_50) begin
    if (bus.o_Tx_DV) begin
      got.push_back(bus.o_Tx_Byte);
      got_cyc.push_back(cyc);
    end
    if (prev_busy && !bus.o_busy) fall_cyc = cyc;
    prev_busy = bus.o_busy;
    done_auto = 0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        done_auto = 1;
        done_cyc.push_back(cyc);
      end
    end
    if (auto_done && bus.o_Tx_DV) resp_cnt = 10;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gc(input int i);
    return i < got_cyc.size() ? got_cyc[i] : -1;
  endfunction

  function automatic int dc(input int i);
    return i < done_cyc.size() ? done_cyc[i] : -100;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic clear();
    got.delete(); got_cyc.delete(); done_cyc.delete(); exp_q.delete();
  endtask

  task automatic push_frame(input logic [15:0] x, input logic [15:0] y);
    exp_q.push_back(8'hAA);
    exp_q.push_back(x[15:8]);
    exp_q.push_back(x[7:0]);
    exp_q.push_back(y[15:8]);
    exp_q.push_back(y[7:0]);
    if (N == 6) exp_q.push_back(x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0]);
  endtask

  task automatic sample(input logic [15:0] x, input logic [15:0] y);
    bus.i_x = x;
    bus.i_y = y;
    bus.i_sample_valid = 1;
    @(negedge clk_50);
    bus.i_sample_valid = 0;
  endtask

  task automatic pulse_done(input bit with_sample, input logic [15:0] x, input logic [15:0] y);
    done_man = 1;
    if (with_sample) begin
      bus.i_x = x;
      bus.i_y = y;
      bus.i_sample_valid = 1;
    end
    @(negedge clk_50);
    done_man = 0;
    bus.i_sample_valid = 0;
  endtask

  task automatic quiet(input string tag);
    int q = 0;
    for (int i = 0; i < 3000 && q < 20; i++) begin
      @(negedge clk_50);
      q = bus.o_busy ? 0 : q + 1;
    end
    chk(tag, q, 20);
  endtask

  task automatic wait_dv(input string tag);
    for (int i = 0; i < 100 && !bus.o_Tx_DV; i++) @(negedge clk_50);
    chk(tag, bus.o_Tx_DV, 1);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dv"}, bus.o_Tx_DV, 0);
    chk({tag, "_byte"}, bus.o_Tx_Byte, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_drop"}, bus.o_drop_cnt, 0);
  endtask

  initial begin
    int s, d, k;
    logic pend;
    logic [15:0] x, y, lx, ly;
    bus.i_sample_valid = 0;
    bus.i_x = 0;
    bus.i_y = 0;
    tick(3);
    check_zero("reset");
    rst = 0;
    tick(1);

    // single frame with fixed sample
    auto_done = 1;
    clear();
    s = cyc;
    sample(16'h1234, 16'hABCD);
    push_frame(16'h1234, 16'hABCD);
    quiet("s1_quiet");
    check_frames("s1");
    chk("s1_hdr_lat", gc(0), s + 1);
    chk("s1_dv_after_done", gc(1), dc(0) + 1);
    chk("s1_busy_fall", fall_cyc, dc(N - 1) + 1 + G);
    chk("s1_drop", bus.o_drop_cnt, 0);

    // overrun: x=2 overwritten by x=3
    clear();
    sample(16'd1, 16'h0011);
    tick(5);
    sample(16'd2, 16'h0022);
    tick(3);
    sample(16'd3, 16'h0033);
    push_frame(16'd1, 16'h0011);
    push_frame(16'd3, 16'h0033);
    m_drop = 1;
    quiet("s2_quiet");
    check_frames("s2");
    chk("s2_drop", bus.o_drop_cnt, m_drop);
    chk("s2_hdr2_gap", gc(N), dc(N - 1) + 2 + G);

    // randomized frames with 0..3 extra samples during each
    for (int r = 0; r < 4; r++) begin
      clear();
      x = 16'($urandom);
      y = 16'($urandom);
      k = $urandom_range(0, 3);
      sample(x, y);
      push_frame(x, y);
      for (int j = 0; j < k; j++) begin
        tick($urandom_range(1, 5));
        lx = 16'($urandom);
        ly = 16'($urandom);
        sample(lx, ly);
      end
      if (k > 0) push_frame(lx, ly);
      if (k > 1) m_drop = m_drop + k - 1 > 255 ? 255 : m_drop + k - 1;
      quiet($sformatf("rnd%0d_quiet", r));
      check_frames($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_drop", r), bus.o_drop_cnt, m_drop);
    end

    // manual UART: spurious dones in IDLE and SEND, sample on the final done
    auto_done = 0;
    clear();
    pulse_done(0, 0, 0);
    tick(2);
    chk("s3_idle_spur", got.size(), 0);
    x = 16'($urandom);
    y = 16'($urandom);
    lx = 16'($urandom);
    ly = 16'($urandom);
    d = 0;
    sample(x, y);
    push_frame(x, y);
    for (int b = 0; b < N; b++) begin
      wait_dv($sformatf("s3_dv%0d", b));
      if (b == 0 || b == 2) pulse_done(0, 0, 0);
      tick(3);
      if (b == N - 1) begin
        d = cyc;
        pulse_done(1, lx, ly);
      end else pulse_done(0, 0, 0);
    end
    auto_done = 1;
    push_frame(lx, ly);
    quiet("s3_quiet");
    check_frames("s3");
    chk("s3_hdr_gap", gc(N), d + 2 + G);
    chk("s3_drop", bus.o_drop_cnt, m_drop);

    // reset while waiting on byte 2
    clear();
    sample(16'h5A5A, 16'hC3C3);
    wait_dv("s5_dv0");
    tick(1);
    wait_dv("s5_dv1");
    tick(1);
    wait_dv("s5_dv2");
    tick(3);
    rst = 1;
    tick(2);
    check_zero("s5_rst");
    rst = 0;
    m_drop = 0;
    tick(15);
    chk("s5_no_dv", got.size(), 3);
    chk("s5_idle", bus.o_busy, 0);
    clear();
    x = 16'($urandom);
    y = 16'($urandom);
    sample(x, y);
    push_frame(x, y);
    quiet("s5_quiet");
    check_frames("s5");
    chk("s5_drop", bus.o_drop_cnt, 0);

    // 300 overwrites while the UART holds the header
    auto_done = 0;
    clear();
    x = 16'($urandom);
    y = 16'($urandom);
    sample(x, y);
    push_frame(x, y);
    pend = 0;
    for (int i = 0; i < 300; i++) begin
      lx = 16'($urandom);
      ly = 16'($urandom);
      bus.i_x = lx;
      bus.i_y = ly;
      bus.i_sample_valid = 1;
      if (pend && m_drop < 255) m_drop++;
      pend = 1;
      @(negedge clk_50);
    end
    bus.i_sample_valid = 0;
    chk("s6_drop_sat", bus.o_drop_cnt, m_drop);
    chk("s6_drop_255", bus.o_drop_cnt, 255);
    auto_done = 1;
    pulse_done(0, 0, 0);
    push_frame(lx, ly);
    quiet("s6_quiet");
    check_frames("s6");
    chk("s6_drop_hold", bus.o_drop_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/accel_tx_packetizer.md
# accel_tx_packetizer

Frames accelerometer X/Y samples into a fixed byte sequence and feeds them one byte at a time to the UART transmitter. It sits directly upstream of the UART TX core: it drives that core's data-valid strobe and byte, and consumes its done pulse. Samples that arrive while a frame is in flight go to a one-deep pending slot; the newest sample wins and overwrites are counted.

## Interface
Parameters:
- HEADER, 8'hAA, first byte of every frame.
- GAP_CYCLES, 0, idle clk_50 cycles inserted after a frame's last done pulse before the next frame may start (0..65535).

Ports:
- clk_50  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_sample_valid  in  1  one-cycle strobe; i_x/i_y valid this cycle.
- i_x  in  16  X sample, two's complement.
- i_y  in  16  Y sample, two's complement.
- o_Tx_DV  out  1  one-cycle pulse: o_Tx_Byte is to be sent.
- o_Tx_Byte  out  8  byte for the UART TX core.
- i_Tx_Done  in  1  one-cycle pulse from the UART TX core: current byte finished.
- o_busy  out  1  high while state != IDLE.
- o_drop_cnt  out  8  saturating count of overwritten pending samples.

## Operation
- States: IDLE, SEND, WAIT_DONE, GAP.
- Frame byte order (index 0..N-1): HEADER, x[15:8], x[7:0], y[15:8], y[7:0], CHK (CHK only with the macro; see Configuration). CHK = XOR of bytes 1..4.
- IDLE: if the pending slot is valid, load it into the frame register and clear the slot. Otherwise, if i_sample_valid is high, load i_x/i_y directly. Either load sets idx=0 and moves to SEND.
- SEND: assert o_Tx_DV for exactly one cycle with o_Tx_Byte = byte[idx], then go to WAIT_DONE.
- WAIT_DONE: on i_Tx_Done, if idx = N-1, go to GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0). Otherwise idx++ and go to SEND.
- GAP: count down GAP_CYCLES, then go to IDLE.
- i_Tx_Done is ignored in every state except WAIT_DONE.
- o_Tx_Byte holds its value from the SEND cycle until the next SEND.
- Pending slot:
  - i_sample_valid when state != IDLE writes the slot.
  - If the slot was already valid, it is overwritten and o_drop_cnt increments, saturating at 255.
- Simultaneous events:
  - In IDLE with the slot valid and i_sample_valid high in the same cycle, the slot's contents are loaded and the new sample is written into the slot. The slot stays valid and no drop is counted.
  - i_sample_valid in the same cycle as the final i_Tx_Done goes to the slot.
- Reset (any state, including mid-frame):
  - state=IDLE, idx=0, slot invalid, o_Tx_DV=0, o_Tx_Byte=0, o_busy=0, o_drop_cnt=0.
  - Any in-progress frame is abandoned.
  - A later i_Tx_Done from the byte the UART is still shifting out is ignored.

## Timing
- Sample accepted in IDLE at edge t: o_Tx_DV=1 during cycle t+1 with o_Tx_Byte=HEADER; o_busy=1 from t+1.
- i_Tx_Done at cycle d (not the last byte): next o_Tx_DV at d+1.
- Last i_Tx_Done at cycle d:
  - GAP_CYCLES=0: IDLE at d+1; if a sample is pending, header o_Tx_DV at d+2.
  - GAP_CYCLES=G: IDLE at d+1+G; header o_Tx_DV at d+2+G.
- Exactly one o_Tx_DV pulse per byte. o_Tx_DV never asserts while in WAIT_DONE.
- Throughput is bounded solely by the UART; the block adds 1 cycle per byte and 1 cycle per frame (plus the gap).

## Configuration
- PKT_CHECKSUM_EN defined: N=6; CHK is appended as byte index 5.
- PKT_CHECKSUM_EN undefined: N=5; the frame ends after y[7:0]. No XOR logic is synthesised.

## Test plan
- Single frame, macro on: x=16'h1234, y=16'hABCD. The bench returns i_Tx_Done 10 cycles after each o_Tx_DV. Expect bytes AA,12,34,AB,CD,40; o_busy falls after the 6th done; o_drop_cnt=0.
- Overrun: three samples during one frame (x=1,2,3). Expect the second frame to carry x=3 and o_drop_cnt=1. No third frame.
- Same-cycle sample on the final i_Tx_Done with GAP_CYCLES=4: next header o_Tx_DV exactly 6 cycles after that done.
- Spurious i_Tx_Done pulses in IDLE and in SEND: no byte skipped, no extra o_Tx_DV.
- Reset asserted during WAIT_DONE of byte 2: all outputs return to 0. A following i_Tx_Done produces no o_Tx_DV. A new sample starts a fresh frame with AA.
- Macro off: same sample as the first scenario gives exactly 5 bytes AA,12,34,AB,CD. Then 300 overwrites give o_drop_cnt=255.
